// File: rtl/boid_mem_sched_if.sv
// Bus bundle for boid_mem_sched: host loader, datapath stream/write-back and display read port.
interface boid_mem_sched_if #(
  parameter int N_BOIDS = 32,
  parameter int IDX_W   = $clog2(N_BOIDS)
);
  logic             start;
  logic             busy;
  logic             done;
  logic             ld_en;
  logic [IDX_W-1:0] ld_addr;
  logic [31:0]      ld_x, ld_y, ld_vx, ld_vy;
  logic [31:0]      x_to_xcel, y_to_xcel, vx_to_xcel, vy_to_xcel;
  logic             r_en_tot;
  logic             r_en_itr;
  logic             acc_clr;
  logic             en_write;
  logic [31:0]      x_from_xcel, y_from_xcel, vx_from_xcel, vy_from_xcel;
  logic [IDX_W-1:0] rd_addr;
  logic [31:0]      rd_x, rd_y;

  modport master (
    output start, ld_en, ld_addr, ld_x, ld_y, ld_vx, ld_vy,
           x_from_xcel, y_from_xcel, vx_from_xcel, vy_from_xcel, rd_addr,
    input  busy, done, x_to_xcel, y_to_xcel, vx_to_xcel, vy_to_xcel,
           r_en_tot, r_en_itr, acc_clr, en_write, rd_x, rd_y
  );

  modport slave (
    input  start, ld_en, ld_addr, ld_x, ld_y, ld_vx, ld_vy,
           x_from_xcel, y_from_xcel, vx_from_xcel, vy_from_xcel, rd_addr,
    output busy, done, x_to_xcel, y_to_xcel, vx_to_xcel, vy_to_xcel,
           r_en_tot, r_en_itr, acc_clr, en_write, rd_x, rd_y
  );
endinterface

// File: rtl/boid_mem_sched.sv
// Flock-state sequencer: streams self + all neighbours to the boid datapath, writes self back
// in place, and serves a read-only display port from the same RAMs.
module boid_mem_sched #(
  parameter int N_BOIDS = 32,
  parameter int IDX_W   = $clog2(N_BOIDS)
) (
  input  logic                clk,
  input  logic                reset,
  boid_mem_sched_if.slave     bus
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_BOIDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_SELF, S_TOT, S_ITR, S_WB, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d, k_q, k_d;
  logic busy_q, busy_d, done_q, done_d;
  logic tot_q, tot_d, itr_q, itr_d, clr_q, clr_d, wr_q, wr_d;
  logic [31:0] x_q, x_d, y_q, y_d, vx_q, vx_d, vy_q, vy_d;
  logic [31:0] rdx_q, rdx_d, rdy_q, rdy_d;

  logic [31:0] mem_x  [N_BOIDS];
  logic [31:0] mem_y  [N_BOIDS];
  logic [31:0] mem_vx [N_BOIDS];
  logic [31:0] mem_vy [N_BOIDS];

  logic             re_a, we_a;
  logic [IDX_W-1:0] addr_a;
  logic [31:0]      wx, wy, wvx, wvy;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    k_d     = k_q;
    re_a    = 1'b0;
    we_a    = 1'b0;
    addr_a  = i_q;
    unique case (state_q)
      S_IDLE: begin
        // A simultaneous load takes priority; start is dropped.
        if (bus.ld_en) begin
          we_a   = 1'b1;
          addr_a = bus.ld_addr;
        end else if (bus.start) begin
          state_d = S_RD_SELF;
          i_d     = '0;
        end
      end
      S_RD_SELF: begin
        re_a    = 1'b1;
        state_d = S_TOT;
      end
      S_TOT: begin
        re_a    = 1'b1;
        addr_a  = '0;
        k_d     = '0;
        state_d = S_ITR;
      end
      S_ITR: begin
        if (k_q == LAST) begin
          state_d = S_WB;
        end else begin
          re_a   = 1'b1;
          addr_a = k_q + IDX_W'(1);
          k_d    = k_q + IDX_W'(1);
        end
      end
      S_WB: begin
        we_a = 1'b1;
        if (i_q == LAST) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + IDX_W'(1);
          state_d = S_RD_SELF;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    wx  = (state_q == S_IDLE) ? bus.ld_x  : bus.x_from_xcel;
    wy  = (state_q == S_IDLE) ? bus.ld_y  : bus.y_from_xcel;
    wvx = (state_q == S_IDLE) ? bus.ld_vx : bus.vx_from_xcel;
    wvy = (state_q == S_IDLE) ? bus.ld_vy : bus.vy_from_xcel;

    // Strobes are registered from the next state so they align with the state they describe.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    tot_d  = (state_d == S_TOT);
    clr_d  = (state_d == S_TOT);
    itr_d  = (state_d == S_ITR);
    wr_d   = (state_d == S_WB);

    x_d  = re_a ? mem_x[addr_a]  : x_q;
    y_d  = re_a ? mem_y[addr_a]  : y_q;
    vx_d = re_a ? mem_vx[addr_a] : vx_q;
    vy_d = re_a ? mem_vy[addr_a] : vy_q;

    rdx_d = mem_x[bus.rd_addr];
    rdy_d = mem_y[bus.rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tot_q   <= 1'b0;
      itr_q   <= 1'b0;
      clr_q   <= 1'b0;
      wr_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      rdx_q   <= '0;
      rdy_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tot_q   <= tot_d;
      itr_q   <= itr_d;
      clr_q   <= clr_d;
      wr_q    <= wr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      rdx_q   <= rdx_d;
      rdy_q   <= rdy_d;
    end
  end

  // RAM arrays carry no reset; a port B read of the written address sees the old word.
  always_ff @(posedge clk) begin
    if (we_a) begin
      mem_x[addr_a]  <= wx;
      mem_y[addr_a]  <= wy;
      mem_vx[addr_a] <= wvx;
      mem_vy[addr_a] <= wvy;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.r_en_tot   = tot_q;
  assign bus.r_en_itr   = itr_q;
  assign bus.acc_clr    = clr_q;
  assign bus.en_write   = wr_q;
  assign bus.x_to_xcel  = x_q;
  assign bus.y_to_xcel  = y_q;
  assign bus.vx_to_xcel = vx_q;
  assign bus.vy_to_xcel = vy_q;
  assign bus.rd_x       = rdx_q;
  assign bus.rd_y       = rdy_q;

endmodule

// File: tb/tb_boid_mem_sched.sv
// Directed bench for boid_mem_sched with N_BOIDS=4 (full checks) and N_BOIDS=5 (timing only).
module tb_boid_mem_sched;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  boid_mem_sched_if #(.N_BOIDS(4), .IDX_W(2)) b4 ();
  boid_mem_sched_if #(.N_BOIDS(5), .IDX_W(3)) b5 ();

  boid_mem_sched #(.N_BOIDS(4), .IDX_W(2)) u4 (.clk(clk), .reset(reset), .bus(b4));
  boid_mem_sched #(.N_BOIDS(5), .IDX_W(3)) u5 (.clk(clk), .reset(reset), .bus(b5));

  // Stub datapath: latch self on r_en_tot, return self + 1.0 on every field.
  logic [31:0] sx = '0, sy = '0, svx = '0, svy = '0;
  always @(posedge clk) begin
    if (b4.r_en_tot) begin
      sx  <= b4.x_to_xcel;
      sy  <= b4.y_to_xcel;
      svx <= b4.vx_to_xcel;
      svy <= b4.vy_to_xcel;
    end
  end
  assign b4.x_from_xcel  = sx  + 32'h0001_0000;
  assign b4.y_from_xcel  = sy  + 32'h0001_0000;
  assign b4.vx_from_xcel = svx + 32'h0001_0000;
  assign b4.vy_from_xcel = svy + 32'h0001_0000;
  assign b5.x_from_xcel  = '0;
  assign b5.y_from_xcel  = '0;
  assign b5.vx_from_xcel = '0;
  assign b5.vy_from_xcel = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Initial flock value of boid j, optionally after one +1.0 update on every field.
  function automatic logic [127:0] pk(input int j, input bit upd);
    logic [31:0] d;
    d = upd ? 32'h0001_0000 : 32'h0;
    return {32'h0010_0000 + 32'(j) + d, 32'h0020_0000 + 32'(j) + d,
            32'hFFFF_0000 + 32'(j) + d, 32'h0000_8000 + 32'(j) + d};
  endfunction

  // Expected {busy,done,r_en_tot,r_en_itr,acc_clr,en_write} in cycle c after start at edge 0.
  function automatic logic [5:0] exp_ctl(input int n, input int c);
    int per, p;
    per = n + 3;
    if (c == n * per + 1) return 6'b110000;
    if (c < 1 || c > n * per + 1) return 6'b000000;
    p = (c - 1) % per;
    return {1'b1, 1'b0, p == 1, (p >= 2 && p < 2 + n), p == 1, p == n + 2};
  endfunction

  function automatic logic [5:0] ctl4();
    return {b4.busy, b4.done, b4.r_en_tot, b4.r_en_itr, b4.acc_clr, b4.en_write};
  endfunction

  function automatic logic [127:0] pres4();
    return {b4.x_to_xcel, b4.y_to_xcel, b4.vx_to_xcel, b4.vy_to_xcel};
  endfunction

  task automatic load4(input int a, input logic [127:0] v);
    b4.ld_en   = 1'b1;
    b4.ld_addr = 2'(a);
    {b4.ld_x, b4.ld_y, b4.ld_vx, b4.ld_vy} = v;
    step();
    b4.ld_en = 1'b0;
  endtask

  initial begin
    logic [127:0] v;
    int b, p;
    reset = 1'b1;
    {b4.start, b4.ld_en, b4.ld_addr, b4.ld_x, b4.ld_y, b4.ld_vx, b4.ld_vy, b4.rd_addr} = '0;
    {b5.start, b5.ld_en, b5.ld_addr, b5.ld_x, b5.ld_y, b5.ld_vx, b5.ld_vy, b5.rd_addr} = '0;
    step();
    chk("reset_ctl", 128'(ctl4()), 128'(0));
    chk("reset_data", {pres4()}, '0);
    chk("reset_rd", 128'({b4.rd_x, b4.rd_y}), '0);
    reset = 1'b0;
    step();

    for (int a = 0; a < 4; a++) load4(a, pk(a, 1'b0));
    for (int a = 0; a < 5; a++) begin
      b5.ld_en = 1'b1;
      b5.ld_addr = 3'(a);
      step();
    end
    b5.ld_en = 1'b0;
    for (int a = 0; a < 4; a++) begin
      b4.rd_addr = 2'(a);
      step();
      v = pk(a, 1'b0);
      chk("load_rd", 128'({b4.rd_x, b4.rd_y}), 128'(v[127:64]));
    end

    // Abandon a frame mid-ITR with an asynchronous reset.
    b4.start = 1'b1;
    step();
    b4.start = 1'b0;
    step();
    step();
    chk("pre_reset_itr", 128'(b4.r_en_itr), 128'(1));
    #2 reset = 1'b1;
    #1;
    chk("midreset_ctl", 128'(ctl4()), 128'(0));
    chk("midreset_data", pres4(), '0);
    chk("midreset_rd", 128'({b4.rd_x, b4.rd_y}), '0);
    #1 reset = 1'b0;
    step();
    chk("post_reset_idle", 128'(ctl4()), 128'(0));

    // Full frame with stub write-back, busy-time requests and display concurrency.
    b4.rd_addr = 2'd2;
    b4.start = 1'b1;
    step();
    b4.start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      b = (c - 1) / 7;
      p = (c - 1) % 7;
      chk($sformatf("ctl_c%0d", c), 128'(ctl4()), 128'(exp_ctl(4, c)));
      if (c <= 28 && p == 1) chk($sformatf("self_b%0d", b), pres4(), pk(b, 1'b0));
      if (c <= 28 && p >= 2 && p <= 5)
        chk($sformatf("nbr_b%0d_k%0d", b, p - 2), pres4(), pk(p - 2, (p - 2) < b));
      if (c == 22) begin
        v = pk(2, 1'b0);
        chk("rd_during_wb", 128'(b4.rd_x), 128'(v[127:96]));
      end
      if (c == 23) begin
        v = pk(2, 1'b1);
        chk("rd_after_wb", 128'(b4.rd_x), 128'(v[127:96]));
      end
      if (c == 10) begin
        b4.ld_en = 1'b1;
        b4.ld_addr = 2'd0;
        {b4.ld_x, b4.ld_y, b4.ld_vx, b4.ld_vy} = {4{32'hDEAD_BEEF}};
        b4.start = 1'b1;
      end
      if (c == 11) begin
        b4.ld_en = 1'b0;
        b4.start = 1'b0;
      end
      if (c == 29) b4.start = 1'b1;
      if (c == 30) b4.start = 1'b0;
      step();
    end
    chk("done_start_ignored", 128'(ctl4()), 128'(0));

    for (int a = 0; a < 4; a++) begin
      b4.rd_addr = 2'(a);
      step();
      v = pk(a, 1'b1);
      chk($sformatf("wb_rd%0d", a), 128'({b4.rd_x, b4.rd_y}), 128'(v[127:64]));
    end

    // start together with ld_en in IDLE: load only.
    b4.start = 1'b1;
    load4(3, {32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0});
    b4.start = 1'b0;
    chk("start_ld_busy", 128'(b4.busy), 128'(0));
    b4.rd_addr = 2'd3;
    step();
    chk("start_ld_busy2", 128'(b4.busy), 128'(0));
    chk("start_ld_rd", 128'({b4.rd_x, b4.rd_y}), 128'({32'h1234_5678, 32'h9ABC_DEF0}));

    // Non-power-of-two flock.
    b5.start = 1'b1;
    step();
    b5.start = 1'b0;
    for (int c = 1; c <= 42; c++) begin
      chk($sformatf("n5_ctl_c%0d", c),
          128'({b5.busy, b5.done, b5.r_en_tot, b5.r_en_itr, b5.acc_clr, b5.en_write}),
          128'(exp_ctl(5, c)));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/boid_mem_sched.md
# boid_mem_sched

Memory-side sequencer for the boid accelerator datapath. It holds the flock state (x, y, vx, vy, signed 16.16 fixed point) in on-chip dual-port RAM and streams it to the datapath:
- the "self" boid, with a total-load strobe;
- every boid as a neighbour, with an iterate strobe;
- then writes the datapath's updated self values back.

A second read port serves the VGA renderer. A host load port initialises the flock while idle.

## Interface
Parameters:
- N_BOIDS, 32, flock size (≥2)
- IDX_W, $clog2(N_BOIDS), boid index width

Ports:
- clk  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin one flock update (frame); honoured only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE, inclusive
- done  out  1  one-cycle pulse at the end of the frame
- ld_en  in  1  host write strobe; honoured only in IDLE
- ld_addr  in  IDX_W  host write index
- ld_x, ld_y, ld_vx, ld_vy  in  32 each  host write data
- x_to_xcel, y_to_xcel, vx_to_xcel, vy_to_xcel  out  32 each  boid data presented to the datapath
- r_en_tot  out  1  datapath latches the presented boid as self
- r_en_itr  out  1  datapath accumulates the presented boid as a neighbour
- acc_clr  out  1  datapath clears its average, close and neighbour-count accumulators
- en_write  out  1  write-back cycle indicator
- x_from_xcel, y_from_xcel, vx_from_xcel, vy_from_xcel  in  32 each  updated self values from the datapath
- rd_addr  in  IDX_W  display read index
- rd_x, rd_y  out  32 each  display read data, 1-cycle latency

## Operation
Storage:
- Four N_BOIDS×32 RAMs, one each for x, y, vx, vy.
- Port A serves the sequencer and the host loader. Synchronous read; the data register resets to 0.
- Port B serves the display; read only.
- RAM contents are not cleared by reset.

FSM states and transitions:
- IDLE: outputs quiet. ld_en writes ld_* to ld_addr. start=1 (and ld_en=0) → RD_SELF with i=0. start and ld_en both high: the load wins and start is ignored.
- RD_SELF: port A address = i. Next state is TOT.
- TOT: presents boid i. Asserts r_en_tot and acc_clr. Issues a read of j=0. Next state is ITR.
- ITR: presents boid k, where k = the address issued in the previous cycle. Asserts r_en_itr. Issues a read of k+1 while k+1 < N_BOIDS. Leaves after k = N_BOIDS−1 has been presented, so ITR lasts exactly N_BOIDS cycles. All boids are presented, including self, in index order. Next state is WB.
- WB: writes the *_from_xcel values into address i. en_write=1.
  - If i = N_BOIDS−1, next state is DONE.
  - Otherwise, i increments and next state is RD_SELF.
- DONE: done=1 for one cycle, then IDLE.

Update and port rules:
- Updates are in place. Boid i+1 already sees boid i's new state.
- busy is high in every state except IDLE.
- start and ld_en are ignored while busy.
- *_to_xcel is the port A read register, valid in TOT and ITR. It is don't-care elsewhere, but holds its last value (no X).

Display port B:
- Independent of the FSM.
- Same-address read during a port A write returns the old data.

Index arithmetic:
- i and k are IDX_W-bit unsigned and never wrap.
- When N_BOIDS is not a power of two, terminal counts are compared against N_BOIDS−1.

## Timing
- Reset (async, any state): state=IDLE; i=k=0; busy, done, r_en_tot, r_en_itr, acc_clr, en_write = 0; *_to_xcel = 0; rd_x, rd_y = 0.
- A mid-frame reset abandons the frame. Boids already written back keep their new values; no partial write occurs.
- Per-boid cost: N_BOIDS+3 cycles (RD_SELF 1, TOT 1, ITR N_BOIDS, WB 1).
- Frame latency: start sampled high in IDLE at edge 0 → done high in cycle N_BOIDS·(N_BOIDS+3)+1. For N_BOIDS=32 this is cycle 1121.
- r_en_tot and r_en_itr are never high together.
- r_en_itr is high on exactly N_BOIDS consecutive cycles per boid.
- en_write is high exactly once per boid, the cycle after the last r_en_itr.
- *_from_xcel is sampled combinationally in WB. The datapath's outputs are combinational from its registers, which are stable after the final ITR edge.
- rd_x and rd_y: rd_addr at edge t → data valid after edge t+1.
- start in the DONE cycle is ignored. A new frame requires start to be seen in IDLE.

## Test plan
- Reset/load: assert reset mid-ITR. Require all outputs 0 and state IDLE. Then load N_BOIDS=4 boids; read them back via port B with 1-cycle latency.
- Sequencing: N_BOIDS=4, start. Require, per boid:
  - r_en_tot with acc_clr in cycle 2;
  - r_en_itr in cycles 3–6 presenting indices 0,1,2,3;
  - en_write in cycle 7;
  - done in cycle 29 (4·7+1).
- Write-back: stub datapath returns self+0x00010000 on all four fields. After one frame, every stored field equals its initial value +1.0. In-place ordering is checked by observing the new boid 0 presented as a neighbour during boid 1.
- Ignored requests: ld_en and start pulsed while busy leave memory and timing unchanged. start and ld_en together in IDLE cause the load only; busy stays 0.
- Display concurrency: port B reads boid 2 during its WB cycle. Require the old value that cycle and the new value on the next read.
- Non-power-of-two: N_BOIDS=5. ITR lasts 5 cycles; done arrives in cycle 41.
